// File: rtl/byte_store_ctrl.sv
// LC-3b store-side write controller: lane-positions STB/STW data, drives byte
// enables and holds the write until mem_r or timeout. Optional macro: STORE_COUNT_EN.
module byte_store_ctrl #(
  parameter int TIMEOUT_CYCLES = 31,
  parameter int TO_W           = 5
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        st_req,
  input  logic        st_byte,
  input  logic [15:0] st_addr,
  input  logic [15:0] st_data,
  output logic        st_busy,
  output logic        st_done,
  output logic        st_err,
  output logic        mem_en,
  output logic [1:0]  mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
`ifdef STORE_COUNT_EN
  output logic [15:0] st_count,
`endif
  input  logic        mem_r
);

  typedef enum logic {IDLE, WRITE} state_t;

  // Last counter value before the timeout fires; the counter counts WRITE edges with mem_r low.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            busy_d, done_d, err_d, en_d;
  logic [1:0]      we_d;
  logic [15:0]     addr_d, wdata_d;
  logic            timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    en_d    = mem_en;
    we_d    = mem_we;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;

    case (state_q)
      IDLE: begin
        if (st_req) begin
          if (!st_byte && st_addr[0]) begin
            err_d = 1'b1;
          end else begin
            state_d = WRITE;
            en_d    = 1'b1;
            cnt_d   = '0;
            addr_d  = {st_addr[15:1], 1'b0};
            if (st_byte) begin
              // Byte is replicated on both lanes; the write enable picks the lane.
              wdata_d = {2{st_data[7:0]}};
              we_d    = st_addr[0] ? 2'b10 : 2'b01;
            end else begin
              wdata_d = st_data;
              we_d    = 2'b11;
            end
          end
        end
      end

      WRITE: begin
        if (mem_r) begin
          state_d = IDLE;
          en_d    = 1'b0;
          we_d    = 2'b00;
          done_d  = 1'b1;
        end else if (timeout_hit) begin
          state_d = IDLE;
          en_d    = 1'b0;
          we_d    = 2'b00;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == WRITE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      st_busy   <= 1'b0;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 2'b00;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      st_busy   <= busy_d;
      st_done   <= done_d;
      st_err    <= err_d;
      mem_en    <= en_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
    end
  end

`ifdef STORE_COUNT_EN
  always_ff @(posedge clk_50) begin
    if (reset) begin
      st_count <= 16'h0000;
    end else if (done_d) begin
      st_count <= st_count + 16'h0001;
    end
  end
`else
  // Completion counter not built.
`endif

endmodule

// File: tb/tb_byte_store_ctrl.sv
// Self-checking bench for byte_store_ctrl: directed cases with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_byte_store_ctrl;

  localparam int TO = 4;

  logic        clk_50 = 1'b0;
  logic        reset, st_req, st_byte, mem_r;
  logic [15:0] st_addr, st_data;
  logic        st_busy, st_done, st_err, mem_en;
  logic [1:0]  mem_we;
  logic [15:0] mem_addr, mem_wdata;
`ifdef STORE_COUNT_EN
  logic [15:0] st_count;
`endif

  always #5 clk_50 = ~clk_50;

  byte_store_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .clk_50    (clk_50),
    .reset     (reset),
    .st_req    (st_req),
    .st_byte   (st_byte),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_busy   (st_busy),
    .st_done   (st_done),
    .st_err    (st_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
`ifdef STORE_COUNT_EN
    .st_count  (st_count),
`endif
    .mem_r     (mem_r)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding store, tracked as "pending"
  // plus the number of WRITE cycles it has waited for mem_r.
  bit          m_pending, m_done, m_err;
  logic [1:0]  m_we;
  logic [15:0] m_addr, m_data, m_count;
  int          m_waited;

  always @(posedge clk_50) begin
    if (reset) begin
      m_pending <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      m_we <= 2'b00; m_addr <= 16'h0; m_data <= 16'h0; m_count <= 16'h0; m_waited <= 0;
    end else begin
      m_done <= 1'b0;
      m_err  <= 1'b0;
      if (!m_pending) begin
        if (st_req) begin
          if (!st_byte && st_addr[0]) begin
            m_err <= 1'b1;
          end else begin
            m_pending <= 1'b1;
            m_waited  <= 0;
            m_addr    <= st_addr & 16'hFFFE;
            m_data    <= st_byte ? {st_data[7:0], st_data[7:0]} : st_data;
            m_we      <= !st_byte ? 2'b11 : (st_addr[0] ? 2'b10 : 2'b01);
          end
        end
      end else if (mem_r) begin
        m_pending <= 1'b0; m_we <= 2'b00; m_done <= 1'b1;
        m_count   <= m_count + 16'h1;
      end else if (m_waited + 1 >= TO) begin
        m_pending <= 1'b0; m_we <= 2'b00; m_err <= 1'b1;
      end else begin
        m_waited <= m_waited + 1;
      end
    end
  end

  always @(negedge clk_50) begin
    if (checking) begin
      check("busy",  st_busy,   m_pending);
      check("en",    mem_en,    m_pending);
      check("done",  st_done,   m_done);
      check("err",   st_err,    m_err);
      check("we",    mem_we,    m_we);
      check("addr",  mem_addr,  m_addr);
      check("wdata", mem_wdata, m_data);
      check("done_err_excl", st_done & st_err, 1'b0);
`ifdef STORE_COUNT_EN
      check("count", st_count, m_count);
`endif
    end
  end

  task automatic req(input logic b, input logic [15:0] a, input logic [15:0] d);
    st_req = 1'b1; st_byte = b; st_addr = a; st_data = d;
  endtask

  initial begin
    reset = 1'b1; st_req = 1'b0; st_byte = 1'b0; st_addr = '0; st_data = '0; mem_r = 1'b0;
    @(posedge clk_50);
    @(negedge clk_50);
    checking = 1'b1;
    check("rst_busy", st_busy, 1'b0);
    check("rst_en",   mem_en,  1'b0);
    check("rst_we",   mem_we,  2'b00);
    check("rst_addr", mem_addr, 16'h0000);
    reset = 1'b0;

    // STB to odd address, immediate ready
    req(1'b1, 16'h3001, 16'hABCD); mem_r = 1'b1;
    @(negedge clk_50);
    st_req = 1'b0;
    check("stb_addr",  mem_addr,  16'h3000);
    check("stb_wdata", mem_wdata, 16'hCDCD);
    check("stb_we",    mem_we,    2'b10);
    check("stb_busy",  st_busy,   1'b1);
    @(negedge clk_50);
    check("stb_done",  st_done,   1'b1);
    check("stb_en_off", mem_en,   1'b0);
    check("stb_addr_kept", mem_addr, 16'h3000);
    mem_r = 1'b0;

    // STW with ready delayed three cycles
    req(1'b0, 16'h4002, 16'h1234);
    @(negedge clk_50);
    st_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stw_we",    mem_we,    2'b11);
      check("stw_wdata", mem_wdata, 16'h1234);
      check("stw_busy",  st_busy,   1'b1);
      check("stw_nodone", st_done,  1'b0);
      if (i == 3) mem_r = 1'b1;
      @(negedge clk_50);
    end
    check("stw_done", st_done, 1'b1);
    mem_r = 1'b0;
    @(negedge clk_50);
    check("stw_done_single", st_done, 1'b0);

    // Misaligned STW
    req(1'b0, 16'h4003, 16'h5678);
    @(negedge clk_50);
    st_req = 1'b0;
    check("mis_err",  st_err,  1'b1);
    check("mis_en",   mem_en,  1'b0);
    check("mis_busy", st_busy, 1'b0);
    @(negedge clk_50);
    check("mis_err_pulse", st_err, 1'b0);

    // Timeout after 4 WRITE edges, then back-to-back STB
    req(1'b0, 16'h0010, 16'h9999);
    @(negedge clk_50);
    st_req = 1'b0;
    repeat (3) @(negedge clk_50);
    check("to_not_yet", st_err, 1'b0);
    check("to_busy",    st_busy, 1'b1);
    @(negedge clk_50);
    check("to_err",  st_err, 1'b1);
    check("to_en",   mem_en, 1'b0);
    req(1'b1, 16'h0000, 16'h0055);
    @(negedge clk_50);
    st_req = 1'b0;
    check("b2b_we",    mem_we,    2'b01);
    check("b2b_wdata", mem_wdata, 16'h5555);
    mem_r = 1'b1;
    @(negedge clk_50);
    check("b2b_done", st_done, 1'b1);
    mem_r = 1'b0;

    // Reset in the second WRITE cycle
    req(1'b0, 16'h0020, 16'hBEEF);
    @(negedge clk_50);
    st_req = 1'b0;
    @(negedge clk_50);
    reset = 1'b1;
    @(negedge clk_50);
    check("mrst_en",    mem_en,    1'b0);
    check("mrst_done",  st_done,   1'b0);
    check("mrst_err",   st_err,    1'b0);
    check("mrst_wdata", mem_wdata, 16'h0000);
    reset = 1'b0;
    req(1'b1, 16'h0005, 16'h0077); mem_r = 1'b1;
    @(negedge clk_50);
    st_req = 1'b0;
    @(negedge clk_50);
    check("post_rst_done",  st_done,   1'b1);
    check("post_rst_wdata", mem_wdata, 16'h7777);
`ifdef STORE_COUNT_EN
    check("post_rst_count", st_count, 16'h0001);
`endif
    mem_r = 1'b0;

    // Randomized traffic
    repeat (3000) begin
      reset   = ($urandom_range(0, 299) == 0);
      st_req  = ($urandom_range(0, 2) == 0);
      st_byte = $urandom_range(0, 1) == 1;
      st_addr = 16'($urandom);
      st_data = 16'($urandom);
      mem_r   = ($urandom_range(0, 3) == 0);
      @(negedge clk_50);
    end

    reset = 1'b0; st_req = 1'b0;
    @(negedge clk_50);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
